rect_draw_scheduler: RTL and testbench

Sequences filled-rectangle draw commands from several requesters into the single-pixel VGA plotting datapath (x, y, colour, plot). Arbitrates round-robin between requesters, then walks the accepted rectangle one pixel per clock, clipping to the 160x120 screen. Sits between the game/drawing logic and the VGA adapter wrapper's x/y/colour/plot inputs.

---
 rtl/rect_draw_scheduler_pkg.sv | 14 +
 rtl/rect_draw_scheduler_rr_arbiter.sv | 41 ++++
 rtl/rect_draw_scheduler.sv | 130 +++++++++++++
 tb/tb_rect_draw_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_draw_scheduler_pkg.sv
// rtl/rect_draw_scheduler_pkg.sv - screen geometry, field widths and FSM encoding shared by the scheduler
package rect_draw_scheduler_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// rtl/rect_draw_scheduler_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer advances past each accepted winner
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic          found;
  int            gidx;
  int            idx;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = 0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (accept && found) begin
      ptr <= PW'((gidx + 1) % NREQ);
    end
  end
endmodule

// File: rtl/rect_draw_scheduler.sv
// rtl/rect_draw_scheduler.sv - arbitrates rectangle fill commands and walks each one a pixel per clock into the VGA plot port
module rect_draw_scheduler #(
  parameter int NREQ     = 2,
  parameter int SCREEN_W = rect_draw_scheduler_pkg::SCREEN_W,
  parameter int SCREEN_H = rect_draw_scheduler_pkg::SCREEN_H
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [7*NREQ-1:0] req_y,
  input  logic [8*NREQ-1:0] req_w,
  input  logic [7*NREQ-1:0] req_h,
  input  logic [3*NREQ-1:0] req_colour,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_done,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy
);
  import rect_draw_scheduler_pkg::*;

  state_t          state;
  logic [XW-1:0]   x0, w, cx;
  logic [YW-1:0]   y0, h, cy;
  logic [CW-1:0]   col;
  logic [NREQ-1:0] gsel, grant;
  logic [XW-1:0]   sel_x, sel_w;
  logic [YW-1:0]   sel_y, sel_h;
  logic [CW-1:0]   sel_c;
  logic            accept, last_px, row_end, drawing;
  logic [XW:0]     xs;
  logic [YW:0]     ys;

  assign accept = (state == S_IDLE) && (|req_valid);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Grant is one-hot, so OR-ing the masked fields selects the winner's command.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x = sel_x | req_x[8*i +: 8];
        sel_y = sel_y | req_y[7*i +: 7];
        sel_w = sel_w | req_w[8*i +: 8];
        sel_h = sel_h | req_h[7*i +: 7];
        sel_c = sel_c | req_colour[3*i +: 3];
      end
    end
  end

  assign row_end = (cx == w - 8'd1);
  assign last_px = row_end && (cy == h - 7'd1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      x0       <= '0;
      y0       <= '0;
      w        <= '0;
      h        <= '0;
      col      <= '0;
      cx       <= '0;
      cy       <= '0;
      gsel     <= '0;
      req_ack  <= '0;
      req_done <= '0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            x0      <= sel_x;
            y0      <= sel_y;
            w       <= sel_w;
            h       <= sel_h;
            col     <= sel_c;
            cx      <= '0;
            cy      <= '0;
            gsel    <= grant;
            req_ack <= grant;
            // An empty rectangle completes in the same cycle it is acknowledged.
            if (sel_w != '0 && sel_h != '0) begin
              state <= S_DRAW;
            end else begin
              state    <= S_DONE;
              req_done <= grant;
            end
          end
        end
        S_DRAW: begin
          if (last_px) begin
            state    <= S_DONE;
            req_done <= gsel;
          end else if (row_end) begin
            cx <= '0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign drawing = (state == S_DRAW);
  assign xs      = {1'b0, x0} + {1'b0, cx};
  assign ys      = {1'b0, y0} + {1'b0, cy};
  assign plot    = drawing && (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
  assign x       = drawing ? xs[7:0] : '0;
  assign y       = drawing ? ys[6:0] : '0;
  assign colour  = drawing ? col : '0;
  assign busy    = (state != S_IDLE);
endmodule

// File: tb/tb_rect_draw_scheduler.sv
// tb/tb_rect_draw_scheduler.sv - directed self-checking bench for rect_draw_scheduler
module tb_rect_draw_scheduler;
  logic        CLOCK_50;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [15:0] req_w;
  logic [13:0] req_h;
  logic [5:0]  req_colour;
  logic [1:0]  req_ack;
  logic [1:0]  req_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  rect_draw_scheduler #(.NREQ(2), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .req_ack    (req_ack),
    .req_done   (req_done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] xx, input logic [6:0] yy,
                         input logic [7:0] ww, input logic [6:0] hh, input logic [2:0] cc);
    req_x[8*i +: 8]      = xx;
    req_y[7*i +: 7]      = yy;
    req_w[8*i +: 8]      = ww;
    req_h[7*i +: 7]      = hh;
    req_colour[3*i +: 3] = cc;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn    = 1'b0;
    req_valid = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    req_w = '0; req_h = '0; req_colour = '0;
    #25;
    n_vec++;
    if ({req_ack, req_done, x, y, colour, plot, busy} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {req_ack, req_done, x, y, colour, plot, busy});
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] ex [6];
    logic [6:0] ey [6];
    ex = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
    ey = '{7'd5, 7'd5, 7'd5, 7'd6, 7'd6, 7'd6};
    do_reset();
    set_req(0, 8'd10, 7'd5, 8'd3, 7'd2, 3'd4);
    req_valid = 2'b01;
    tick();
    n_vec++;
    if (req_ack !== 2'b01 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_ack: got ack=%b busy=%b want ack=01 busy=1", req_ack, busy);
    end
    req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      n_vec++;
      if (plot !== 1'b1 || x !== ex[k] || y !== ey[k] || colour !== 3'd4 || req_done !== 2'b00) begin
        n_err++;
        $display("FAIL single_pixel%0d: got plot=%b x=%0d y=%0d c=%0d done=%b want plot=1 x=%0d y=%0d c=4 done=00",
                 k, plot, x, y, colour, req_done, ex[k], ey[k]);
      end
    end
    tick();
    n_vec++;
    if (req_done !== 2'b01 || plot !== 1'b0 || x !== 8'd0 || colour !== 3'd0) begin
      n_err++;
      $display("FAIL single_done: got done=%b plot=%b x=%0d c=%0d want done=01 plot=0 x=0 c=0",
               req_done, plot, x, colour);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || req_done !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b done=%b want busy=0 done=00", busy, req_done);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack [4];
    int cnt;
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    set_req(0, 8'd20, 7'd20, 8'd1, 7'd1, 3'd1);
    set_req(1, 8'd30, 7'd30, 8'd1, 7'd1, 3'd2);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (req_ack == 2'b00 && cnt < 10);
      n_vec++;
      if (req_ack !== exp_ack[c] || x !== (exp_ack[c][0] ? 8'd20 : 8'd30) || plot !== 1'b1) begin
        n_err++;
        $display("FAIL rr_grant%0d: got ack=%b x=%0d plot=%b want ack=%b x=%0d plot=1",
                 c, req_ack, x, plot, exp_ack[c], exp_ack[c][0] ? 20 : 30);
      end
      n_vec++;
      if (cnt !== ((c == 0) ? 1 : 3)) begin
        n_err++;
        $display("FAIL rr_spacing%0d: got %0d cycles want %0d", c, cnt, (c == 0) ? 1 : 3);
      end
    end
    req_valid = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_clip();
    logic [7:0] exp_x;
    logic [6:0] exp_y;
    logic       exp_plot;
    do_reset();
    set_req(1, 8'd158, 7'd119, 8'd4, 7'd2, 3'd5);
    req_valid = 2'b10;
    tick();
    n_vec++;
    if (req_ack !== 2'b10) begin
      n_err++;
      $display("FAIL clip_ack: got %b want 10", req_ack);
    end
    req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      exp_x    = 8'(158 + (k % 4));
      exp_y    = 7'(119 + (k / 4));
      exp_plot = (k < 2);
      n_vec++;
      if (plot !== exp_plot || x !== exp_x || y !== exp_y || colour !== 3'd5 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL clip_pixel%0d: got plot=%b x=%0d y=%0d c=%0d want plot=%b x=%0d y=%0d c=5",
                 k, plot, x, y, colour, exp_plot, exp_x, exp_y);
      end
    end
    tick();
    n_vec++;
    if (req_done !== 2'b10 || plot !== 1'b0) begin
      n_err++;
      $display("FAIL clip_done: got done=%b plot=%b want done=10 plot=0", req_done, plot);
    end
    tick();
  endtask

  task automatic test_empty();
    logic [7:0] ws [2];
    logic [6:0] hs [2];
    ws = '{8'd0, 8'd5};
    hs = '{7'd3, 7'd0};
    for (int t = 0; t < 2; t++) begin
      set_req(0, 8'd40, 7'd40, ws[t], hs[t], 3'd7);
      req_valid = 2'b01;
      tick();
      n_vec++;
      if (req_ack !== 2'b01 || req_done !== 2'b01 || plot !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL empty%0d_ackdone: got ack=%b done=%b plot=%b busy=%b want 01 01 0 1",
                 t, req_ack, req_done, plot, busy);
      end
      req_valid = 2'b00;
      tick();
      n_vec++;
      if (busy !== 1'b0 || req_done !== 2'b00 || plot !== 1'b0) begin
        n_err++;
        $display("FAIL empty%0d_idle: got busy=%b done=%b plot=%b want 0 00 0", t, busy, req_done, plot);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int cnt;
    int done0_seen;
    done0_seen = 0;
    do_reset();
    set_req(0, 8'd0, 7'd0, 8'd10, 7'd10, 3'd3);
    req_valid = 2'b01;
    tick();
    n_vec++;
    if (req_ack !== 2'b01) begin
      n_err++;
      $display("FAIL abort_ack0: got %b want 01", req_ack);
    end
    set_req(1, 8'd50, 7'd50, 8'd1, 7'd1, 3'd6);
    req_valid = 2'b10;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (req_done[0]) done0_seen++;
    end
    n_vec++;
    if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd2) begin
      n_err++;
      $display("FAIL abort_middraw: got plot=%b x=%0d y=%0d want plot=1 x=0 y=2", plot, x, y);
    end
    #5;
    resetn = 1'b0;
    #1;
    n_vec++;
    if ({req_ack, req_done, x, y, colour, plot, busy} !== 27'd0) begin
      n_err++;
      $display("FAIL abort_async_zero: got %h want 0", {req_ack, req_done, x, y, colour, plot, busy});
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (req_done[0]) done0_seen++;
    end while (req_ack == 2'b00 && cnt < 5);
    n_vec++;
    if (req_ack !== 2'b10 || x !== 8'd50) begin
      n_err++;
      $display("FAIL abort_pending_r1: got ack=%b x=%0d want ack=10 x=50", req_ack, x);
    end
    req_valid = 2'b00;
    tick();
    if (req_done[0]) done0_seen++;
    n_vec++;
    if (req_done !== 2'b10) begin
      n_err++;
      $display("FAIL abort_r1_done: got %b want 10", req_done);
    end
    tick();
    n_vec++;
    if (done0_seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_done0: got %0d done pulses want 0", done0_seen);
    end
  endtask

  task automatic test_withdraw();
    int r1_events;
    int done0;
    r1_events = 0;
    done0     = 0;
    do_reset();
    set_req(0, 8'd0, 7'd0, 8'd1, 7'd4, 3'd1);
    set_req(1, 8'd99, 7'd9, 8'd2, 7'd2, 3'd2);
    req_valid = 2'b01;
    tick();
    n_vec++;
    if (req_ack !== 2'b01) begin
      n_err++;
      $display("FAIL withdraw_ack0: got %b want 01", req_ack);
    end
    req_valid = 2'b10;
    tick();
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (req_ack[1] || req_done[1] || (plot && x == 8'd99)) r1_events++;
      if (req_done[0]) done0++;
    end
    n_vec++;
    if (r1_events !== 0) begin
      n_err++;
      $display("FAIL withdraw_r1_silent: got %0d r1 events want 0", r1_events);
    end
    n_vec++;
    if (done0 !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL withdraw_r0_done: got done0=%0d busy=%b want 1 0", done0, busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clip();
    test_empty();
    test_reset_mid_draw();
    test_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
